lsu_ctrl: RTL

- Load/store unit between the core's execute stage and the word-organised data memory (256 x 32, combinational read, write on clk edge).
- Converts RV32I byte/halfword/word loads and stores into whole-word memory accesses.
- Sub-word stores use read-modify-write; load data is sign/zero-extended.
- Misaligned, out-of-range and illegal-funct3 requests are flagged.
- Handshake is valid/ready, so the core stalls while the unit is busy.

---
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns RV32I byte/half/word accesses into whole-word memory
// cycles, with read-modify-write for sub-word stores and sign/zero extension.
module lsu_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // LOAD  | read word, extend selected lane into resp data
  // MERGE | read word, splice store lane into write buffer
  // WRITE | drive write buffer to memory for one cycle
  // RESP  | one-cycle response pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_WRITE, S_RESP} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        f3_ok, misal, oor, req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    f3_ok = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Catches both index >= depth and any nonzero bits above the index range.
    oor     = {2'b00, req_addr[ADDR_W-1:2]} >= DEPTH_L;
    req_err = !f3_ok || misal || oor;
  end

  always_comb begin
    lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'd0, lane_b};
      3'b101:  load_ext = {16'd0, lane_h};
      default: load_ext = mem_rdata;
    endcase
    // wbuf still holds the raw store data while in MERGE.
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wbuf_q   <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                   state_d = S_RESP;
          else if (!req_we)              state_d = S_LOAD;
          else if (req_funct3 == 3'b010) state_d = S_WRITE;
          else                           state_d = S_MERGE;
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wbuf_d   = req_wdata;
          if (req_err) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        err_d   = 1'b0;
      end
      S_MERGE: wbuf_d = merged;
      S_WRITE: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    mem_we     = (state_q == S_WRITE);
    mem_wdata  = (state_q == S_WRITE) ? wbuf_q : 32'd0;
    mem_addr   = '0;
    if (state_q == S_LOAD || state_q == S_MERGE || state_q == S_WRITE)
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
